datapath: RTL and testbench

- 32-bit single-bus CPU datapath for the Phase 1 control-signal-driven CPU.
- Contains PC, IR, MAR, MDR, Y, a 64-bit Z (ZHI/ZLO), general registers R3, R4 and R7, a shared bus multiplexer, and an ALU.
- Every transfer is commanded by external one-hot out/enable strobes from a control sequencer (a testbench in Phase 1).
- Internal state is exposed on debug outputs for verification.

---
 rtl/cpu_pkg.sv | 29 ++
 rtl/alu.sv | 84 ++++++++
 rtl/datapath.sv | 118 +++++++++++
 tb/tb_datapath.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the Phase 1 single-bus CPU: datapath width and the
// ALU operation encodings driven by the control sequencer on op_code.
package cpu_pkg;

    localparam int unsigned WIDTH = 32;
    localparam int unsigned OPW   = 5;

    // ALU operation encodings
    localparam logic [OPW-1:0] OP_LD   = 5'b00000;
    localparam logic [OPW-1:0] OP_LDI  = 5'b00001;
    localparam logic [OPW-1:0] OP_ST   = 5'b00010;
    localparam logic [OPW-1:0] OP_ADD  = 5'b00011;
    localparam logic [OPW-1:0] OP_SUB  = 5'b00100;
    localparam logic [OPW-1:0] OP_AND  = 5'b00101;
    localparam logic [OPW-1:0] OP_OR   = 5'b00110;
    localparam logic [OPW-1:0] OP_ROR  = 5'b00111;
    localparam logic [OPW-1:0] OP_ROL  = 5'b01000;
    localparam logic [OPW-1:0] OP_SHR  = 5'b01001;
    localparam logic [OPW-1:0] OP_SHRA = 5'b01010;
    localparam logic [OPW-1:0] OP_SHL  = 5'b01011;
    localparam logic [OPW-1:0] OP_ADDI = 5'b01100;
    localparam logic [OPW-1:0] OP_ANDI = 5'b01101;
    localparam logic [OPW-1:0] OP_ORI  = 5'b01110;
    localparam logic [OPW-1:0] OP_DIV  = 5'b01111;
    localparam logic [OPW-1:0] OP_MUL  = 5'b10000;
    localparam logic [OPW-1:0] OP_NEG  = 5'b10001;
    localparam logic [OPW-1:0] OP_NOT  = 5'b10010;

endpackage

// File: rtl/alu.sv
// Combinational ALU for the single-bus datapath.
// Ports:
//   a_i       - operand A (Y register)
//   b_i       - operand B (bus)
//   op_code_i - operation select (encodings in cpu_pkg)
//   c_o       - 64-bit result; upper half lands in ZHI, lower half in ZLO
module alu
    import cpu_pkg::*;
#(
    parameter int unsigned W = WIDTH
) (
    input  logic [W-1:0]   a_i,
    input  logic [W-1:0]   b_i,
    input  logic [OPW-1:0] op_code_i,
    output logic [2*W-1:0] c_o
);

    localparam int unsigned SW = $clog2(W);

    logic [SW-1:0]         sh_amt;
    logic [2*W-1:0]        a_dup;
    logic [2*W-1:0]        ror_full;
    logic [2*W-1:0]        rol_full;
    logic signed [2*W-1:0] prod;
    logic [W-1:0]          min_neg;
    logic [W-1:0]          hi;
    logic [W-1:0]          lo;

    // Only the low bits of B select the shift/rotate distance
    assign sh_amt  = b_i[SW-1:0];
    assign min_neg = {1'b1, {(W-1){1'b0}}};

    // Rotates are taken from a doubled copy of A so amount 0 falls out as A
    assign a_dup    = {a_i, a_i};
    assign ror_full = a_dup >> sh_amt;
    assign rol_full = a_dup << sh_amt;

    // Full-width signed product from sign-extended operands
    assign prod = $signed({{W{a_i[W-1]}}, a_i}) * $signed({{W{b_i[W-1]}}, b_i});

    // Operation select
    always_comb begin
        hi = '0;
        lo = '0;
        case (op_code_i)
            OP_LD, OP_LDI, OP_ST, OP_ADD, OP_ADDI: lo = a_i + b_i;
            OP_SUB:                                lo = a_i - b_i;
            OP_AND, OP_ANDI:                       lo = a_i & b_i;
            OP_OR, OP_ORI:                         lo = a_i | b_i;
            OP_ROR:                                lo = ror_full[W-1:0];
            OP_ROL:                                lo = rol_full[2*W-1:W];
            OP_SHR:                                lo = a_i >> sh_amt;
            OP_SHRA:                               lo = W'($signed(a_i) >>> sh_amt);
            OP_SHL:                                lo = a_i << sh_amt;
            OP_DIV: begin
                if (b_i == '0) begin
                    // Divide by zero: all-ones quotient, dividend as remainder
                    lo = '1;
                    hi = a_i;
                end else if ((a_i == min_neg) && (b_i == '1)) begin
                    // Overflowing quotient wraps; remainder is exactly zero
                    lo = min_neg;
                    hi = '0;
                end else begin
                    lo = W'($signed(a_i) / $signed(b_i));
                    hi = W'($signed(a_i) % $signed(b_i));
                end
            end
            OP_MUL: begin
                lo = prod[W-1:0];
                hi = prod[2*W-1:W];
            end
            OP_NEG:                                lo = W'(0) - b_i;
            OP_NOT:                                lo = ~b_i;
            default: begin
                hi = '0;
                lo = '0;
            end
        endcase
    end

    assign c_o = {hi, lo};

endmodule

// File: rtl/datapath.sv
// Single-bus CPU datapath: PC, IR, MAR, MDR, Y, Z (ZHI/ZLO), R3, R4, R7,
// a priority bus multiplexer and the ALU. Every transfer is commanded by
// external out/enable strobes; all register contents are visible as outputs.
// Ports:
//   clk, clr                     - clock, async active-high clear
//   *_out                        - bus source selects
//   *_enable, pc_increment       - register load / PC increment strobes
//   read                         - MDR takes m_data_in instead of the bus
//   op_code                      - ALU operation
//   m_data_in                    - memory read data
//   bus_q                        - current bus value (combinational)
//   pc_q .. r7_q                 - register contents
module datapath #(
    parameter int unsigned       WIDTH    = cpu_pkg::WIDTH,
    parameter logic [WIDTH-1:0]  PC_RESET = '0
) (
    input  logic                     clk,
    input  logic                     clr,
    input  logic                     pc_out,
    input  logic                     zlo_out,
    input  logic                     zhi_out,
    input  logic                     mdr_out,
    input  logic                     r3_out,
    input  logic                     r4_out,
    input  logic                     r7_out,
    input  logic                     pc_enable,
    input  logic                     mar_enable,
    input  logic                     mdr_enable,
    input  logic                     ir_enable,
    input  logic                     y_enable,
    input  logic                     z_enable,
    input  logic                     r3_enable,
    input  logic                     r4_enable,
    input  logic                     r7_enable,
    input  logic                     pc_increment,
    input  logic                     read,
    input  logic [cpu_pkg::OPW-1:0]  op_code,
    input  logic [WIDTH-1:0]         m_data_in,
    output logic [WIDTH-1:0]         bus_q,
    output logic [WIDTH-1:0]         pc_q,
    output logic [WIDTH-1:0]         ir_q,
    output logic [WIDTH-1:0]         mar_q,
    output logic [WIDTH-1:0]         mdr_q,
    output logic [WIDTH-1:0]         y_q,
    output logic [WIDTH-1:0]         zhi_q,
    output logic [WIDTH-1:0]         zlo_q,
    output logic [WIDTH-1:0]         r3_q,
    output logic [WIDTH-1:0]         r4_q,
    output logic [WIDTH-1:0]         r7_q
);

    import cpu_pkg::*;

    logic [WIDTH-1:0]   pc_d;
    logic [WIDTH-1:0]   mdr_d;
    logic [2*WIDTH-1:0] alu_c;

    // Bus multiplexer: fixed priority, idle bus reads zero
    always_comb begin
        bus_q = '0;
        if (pc_out)       bus_q = pc_q;
        else if (zlo_out) bus_q = zlo_q;
        else if (zhi_out) bus_q = zhi_q;
        else if (mdr_out) bus_q = mdr_q;
        else if (r3_out)  bus_q = r3_q;
        else if (r4_out)  bus_q = r4_q;
        else if (r7_out)  bus_q = r7_q;
    end

    // PC next value: an explicit load wins over increment
    always_comb begin
        pc_d = pc_q;
        if (pc_enable)         pc_d = bus_q;
        else if (pc_increment) pc_d = pc_q + WIDTH'(1);
    end

    // MDR input mux
    assign mdr_d = read ? m_data_in : bus_q;

    alu #(
        .W (WIDTH)
    ) u_alu (
        .a_i       (y_q),
        .b_i       (bus_q),
        .op_code_i (op_code),
        .c_o       (alu_c)
    );

    // Register file of the datapath; every load samples the pre-edge bus
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            pc_q  <= PC_RESET;
            ir_q  <= '0;
            mar_q <= '0;
            mdr_q <= '0;
            y_q   <= '0;
            zhi_q <= '0;
            zlo_q <= '0;
            r3_q  <= '0;
            r4_q  <= '0;
            r7_q  <= '0;
        end else begin
            pc_q <= pc_d;
            if (ir_enable)  ir_q  <= bus_q;
            if (mar_enable) mar_q <= bus_q;
            if (mdr_enable) mdr_q <= mdr_d;
            if (y_enable)   y_q   <= bus_q;
            if (z_enable) begin
                zhi_q <= alu_c[2*WIDTH-1:WIDTH];
                zlo_q <= alu_c[WIDTH-1:0];
            end
            if (r3_enable)  r3_q  <= bus_q;
            if (r4_enable)  r4_q  <= bus_q;
            if (r7_enable)  r7_q  <= bus_q;
        end
    end

endmodule

// File: tb/tb_datapath.sv
// Self-checking bench for datapath: register expectations are queued when a
// control step is driven and compared right after the clock edge that
// performs the load.
module tb_datapath;

    localparam int unsigned W = 32;

    localparam int S_PC  = 0;
    localparam int S_IR  = 1;
    localparam int S_MAR = 2;
    localparam int S_MDR = 3;
    localparam int S_Y   = 4;
    localparam int S_ZHI = 5;
    localparam int S_ZLO = 6;
    localparam int S_R3  = 7;
    localparam int S_R4  = 8;
    localparam int S_R7  = 9;

    typedef struct {
        string        tag;
        int           sel;
        logic [W-1:0] exp;
    } sb_entry_t;

    logic         clk = 1'b0;
    logic         clr;
    logic         pc_out, zlo_out, zhi_out, mdr_out, r3_out, r4_out, r7_out;
    logic         pc_enable, mar_enable, mdr_enable, ir_enable, y_enable;
    logic         z_enable, r3_enable, r4_enable, r7_enable;
    logic         pc_increment, read;
    logic [4:0]   op_code;
    logic [W-1:0] m_data_in;
    logic [W-1:0] bus_q, pc_q, ir_q, mar_q, mdr_q, y_q, zhi_q, zlo_q;
    logic [W-1:0] r3_q, r4_q, r7_q;

    sb_entry_t sb[$];
    int n_checks = 0;
    int n_errors = 0;

    logic [4:0]   sh_ops [5] = '{5'b00111, 5'b01000, 5'b01001, 5'b01010, 5'b01011};
    logic [W-1:0] sh_exp [5] = '{32'hC000_0000, 32'h0000_0003, 32'h4000_0000,
                                 32'hC000_0000, 32'h0000_0002};

    datapath #(
        .WIDTH    (W),
        .PC_RESET (32'h0)
    ) dut (
        .clk          (clk),
        .clr          (clr),
        .pc_out       (pc_out),
        .zlo_out      (zlo_out),
        .zhi_out      (zhi_out),
        .mdr_out      (mdr_out),
        .r3_out       (r3_out),
        .r4_out       (r4_out),
        .r7_out       (r7_out),
        .pc_enable    (pc_enable),
        .mar_enable   (mar_enable),
        .mdr_enable   (mdr_enable),
        .ir_enable    (ir_enable),
        .y_enable     (y_enable),
        .z_enable     (z_enable),
        .r3_enable    (r3_enable),
        .r4_enable    (r4_enable),
        .r7_enable    (r7_enable),
        .pc_increment (pc_increment),
        .read         (read),
        .op_code      (op_code),
        .m_data_in    (m_data_in),
        .bus_q        (bus_q),
        .pc_q         (pc_q),
        .ir_q         (ir_q),
        .mar_q        (mar_q),
        .mdr_q        (mdr_q),
        .y_q          (y_q),
        .zhi_q        (zhi_q),
        .zlo_q        (zlo_q),
        .r3_q         (r3_q),
        .r4_q         (r4_q),
        .r7_q         (r7_q)
    );

    always #5 clk = ~clk;

    function automatic logic [W-1:0] get_reg(input int sel);
        case (sel)
            S_PC:    return pc_q;
            S_IR:    return ir_q;
            S_MAR:   return mar_q;
            S_MDR:   return mdr_q;
            S_Y:     return y_q;
            S_ZHI:   return zhi_q;
            S_ZLO:   return zlo_q;
            S_R3:    return r3_q;
            S_R4:    return r4_q;
            default: return r7_q;
        endcase
    endfunction

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic expect_reg(input string tag, input int sel, input logic [W-1:0] v);
        sb_entry_t e;
        e.tag = tag;
        e.sel = sel;
        e.exp = v;
        sb.push_back(e);
    endtask

    task automatic idle();
        {pc_out, zlo_out, zhi_out, mdr_out, r3_out, r4_out, r7_out} = '0;
        {pc_enable, mar_enable, mdr_enable, ir_enable, y_enable} = '0;
        {z_enable, r3_enable, r4_enable, r7_enable} = '0;
        pc_increment = 1'b0;
        read         = 1'b0;
        op_code      = 5'b0;
        m_data_in    = '0;
    endtask

    // One clock edge, then drain the scoreboard and release all strobes
    task automatic step();
        sb_entry_t e;
        @(posedge clk);
        #1;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            check(e.tag, get_reg(e.sel), e.exp);
        end
        idle();
    endtask

    task automatic load_mdr(input logic [W-1:0] v);
        read = 1'b1; m_data_in = v; mdr_enable = 1'b1;
        step();
    endtask

    task automatic alu_case(input string tag, input logic [W-1:0] yv, input logic [W-1:0] bv,
                            input logic [4:0] op, input logic [W-1:0] lo, input logic [W-1:0] hi);
        load_mdr(yv);
        mdr_out = 1'b1; y_enable = 1'b1;
        step();
        load_mdr(bv);
        mdr_out = 1'b1; op_code = op; z_enable = 1'b1;
        expect_reg({tag, "_lo"}, S_ZLO, lo);
        expect_reg({tag, "_hi"}, S_ZHI, hi);
        step();
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        idle();
        clr = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        for (int s = 0; s < 10; s++) check($sformatf("reset_%0d", s), get_reg(s), 32'h0);
        check("bus_idle", bus_q, 32'h0);
        clr = 1'b0;

        // AND program: preload registers through MDR
        load_mdr(32'h22); mdr_out = 1'b1; r3_enable = 1'b1; expect_reg("r3_ld", S_R3, 32'h22); step();
        load_mdr(32'h24); mdr_out = 1'b1; r7_enable = 1'b1; expect_reg("r7_ld", S_R7, 32'h24); step();
        load_mdr(32'h28); mdr_out = 1'b1; r4_enable = 1'b1; expect_reg("r4_ld", S_R4, 32'h28); step();
        // T0
        pc_out = 1'b1; mar_enable = 1'b1; pc_increment = 1'b1;
        expect_reg("t0_mar", S_MAR, 32'h0); expect_reg("t0_pc", S_PC, 32'h1);
        step();
        pc_out = 1'b1; r4_enable = 1'b1;
        expect_reg("t0_r4", S_R4, 32'h1);
        step();
        // T1
        m_data_in = 32'h2A1B_8000; read = 1'b1; mdr_enable = 1'b1; r4_out = 1'b1; pc_enable = 1'b1;
        expect_reg("t1_mdr", S_MDR, 32'h2A1B_8000); expect_reg("t1_pc", S_PC, 32'h1);
        step();
        // T2
        mdr_out = 1'b1; ir_enable = 1'b1; expect_reg("t2_ir", S_IR, 32'h2A1B_8000); step();
        // T3
        r3_out = 1'b1; y_enable = 1'b1; expect_reg("t3_y", S_Y, 32'h22); step();
        // T4
        r7_out = 1'b1; op_code = 5'b00101; z_enable = 1'b1;
        expect_reg("t4_zlo", S_ZLO, 32'h20); expect_reg("t4_zhi", S_ZHI, 32'h0);
        step();
        // T5
        zlo_out = 1'b1; r4_enable = 1'b1; expect_reg("t5_r4", S_R4, 32'h20); step();
        check("and_mar", mar_q, 32'h0);
        check("and_pc", pc_q, 32'h1);

        // Arithmetic, multiply, divide, unary and unused codes
        alu_case("add",  32'h7FFF_FFFF, 32'h1, 5'b00011, 32'h8000_0000, 32'h0);
        alu_case("sub",  32'h5, 32'h7, 5'b00100, 32'hFFFF_FFFE, 32'h0);
        alu_case("mul",  32'hFFFF_FFFE, 32'h3, 5'b10000, 32'hFFFF_FFFA, 32'hFFFF_FFFF);
        alu_case("div",  32'hFFFF_FFF9, 32'h2, 5'b01111, 32'hFFFF_FFFD, 32'hFFFF_FFFF);
        alu_case("div0", 32'h9, 32'h0, 5'b01111, 32'hFFFF_FFFF, 32'h9);
        alu_case("or",   32'hF0, 32'h0F, 5'b01110, 32'hFF, 32'h0);
        alu_case("neg",  32'h1, 32'h5, 5'b10001, 32'hFFFF_FFFB, 32'h0);
        alu_case("not",  32'h1, 32'h0F0F_0F0F, 5'b10010, 32'hF0F0_F0F0, 32'h0);
        alu_case("mul_p", 32'h1234_5678, 32'h100, 5'b10000, 32'h3456_7800, 32'h12);
        alu_case("other", 32'h3, 32'h4, 5'b11111, 32'h0, 32'h0);

        // Shifts and rotates, normal amount then amount 0 via bus=32
        for (int i = 0; i < 5; i++) begin
            alu_case($sformatf("sh%0d", i), 32'h8000_0001, 32'h1, sh_ops[i], sh_exp[i], 32'h0);
            alu_case($sformatf("sh0_%0d", i), 32'h8000_0001, 32'd32, sh_ops[i], 32'h8000_0001, 32'h0);
        end

        // PC: load beats increment, then wrap
        load_mdr(32'h1234);
        mdr_out = 1'b1; pc_enable = 1'b1; pc_increment = 1'b1;
        expect_reg("pc_prio", S_PC, 32'h1234);
        step();
        load_mdr(32'hFFFF_FFFF);
        mdr_out = 1'b1; pc_enable = 1'b1; expect_reg("pc_ff", S_PC, 32'hFFFF_FFFF); step();
        pc_increment = 1'b1; expect_reg("pc_wrap", S_PC, 32'h0); step();
        pc_increment = 1'b1; step();

        // Bus priority and idle bus
        pc_out = 1'b1; r3_out = 1'b1; #1;
        check("bus_pc_r3", bus_q, 32'h1);
        pc_out = 1'b0; #1;
        check("bus_r3", bus_q, 32'h22);
        idle(); #1;
        check("bus_none", bus_q, 32'h0);

        // Same register as source and destination
        r3_out = 1'b1; r3_enable = 1'b1; expect_reg("r3_self", S_R3, 32'h22); step();

        // Asynchronous clear between edges, then loads resume
        clr = 1'b1;
        #2;
        for (int s = 0; s < 10; s++) check($sformatf("aclr_%0d", s), get_reg(s), 32'h0);
        clr = 1'b0;
        load_mdr(32'hABCD);
        check("post_clr_mdr", mdr_q, 32'hABCD);
        mdr_out = 1'b1; r7_enable = 1'b1; expect_reg("post_clr_r7", S_R7, 32'hABCD); step();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
